// File: rtl/tlc1543_emu_if.sv
// Three-wire TLC1543 serial link: I/O clock, chip select and address from the
// controller, serial data and end-of-conversion back from the ADC.
interface tlc1543_emu_if;
  logic tlc1543_clk;
  logic tlc1543_cs_n;
  logic tlc1543_addr;
  logic tlc1543_data;
  logic tlc1543_eoc;

  modport master (
    output tlc1543_clk,
    output tlc1543_cs_n,
    output tlc1543_addr,
    input  tlc1543_data,
    input  tlc1543_eoc
  );

  modport slave (
    input  tlc1543_clk,
    input  tlc1543_cs_n,
    input  tlc1543_addr,
    output tlc1543_data,
    output tlc1543_eoc
  );
endinterface

// File: rtl/tlc1543_emu.sv
// TLC1543 ADC emulator: shifts out the previous result while capturing the next
// channel address, then runs a timed conversion from a host-writable value table.
module tlc1543_emu #(
  parameter int CONV_CYCLES = 1050
) (
  input  logic         clk_50m,
  input  logic         rst,
  tlc1543_emu_if.slave pins,
  input  logic         ch_wr_en,
  input  logic [3:0]   ch_wr_addr,
  input  logic [9:0]   ch_wr_data,
  output logic         conv_done,
  output logic [3:0]   conv_ch,
  output logic [9:0]   conv_result,
  output logic         frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sclk_sync_reg, cs_sync_reg, addr_sync_reg;
  logic        sclk_d_reg, cs_d_reg;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [9:0]  tx_sh_reg, tx_sh_next;
  logic [3:0]  edge_cnt_reg, edge_cnt_next, edge_cnt_inc;
  logic [3:0]  addr_sh_reg, addr_sh_next;
  logic        start_req, frame_err_next;

  logic        eoc_reg;
  logic [15:0] cnt_reg;
  logic [3:0]  conv_ch_lat_reg;
  logic [9:0]  conv_val_reg;
  logic [9:0]  result_reg;
  logic        conv_done_reg, frame_err_reg;
  logic [3:0]  conv_ch_reg;
  logic [9:0]  conv_result_reg;

  logic [10:0][9:0] table_val;
  logic [9:0]       ch_value;

  // Idle levels on reset so no spurious edge is seen when reset releases.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= 2'b00;
      cs_sync_reg   <= 2'b11;
      addr_sync_reg <= 2'b00;
      sclk_d_reg    <= 1'b0;
      cs_d_reg      <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], pins.tlc1543_clk};
      cs_sync_reg   <= {cs_sync_reg[0], pins.tlc1543_cs_n};
      addr_sync_reg <= {addr_sync_reg[0], pins.tlc1543_addr};
      sclk_d_reg    <= sclk_sync_reg[1];
      cs_d_reg      <= cs_sync_reg[1];
    end
  end

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_d_reg;
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_d_reg;
  assign cs_fall   = ~cs_sync_reg[1] & cs_d_reg;
  assign cs_rise   = cs_sync_reg[1] & ~cs_d_reg;

  generate
    for (genvar gi = 0; gi < 11; gi++) begin : g_table
      logic [9:0] entry_reg;
      always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
          entry_reg <= 10'(gi * 64);
        end else if (ch_wr_en && ch_wr_addr == 4'(gi)) begin
          entry_reg <= ch_wr_data;
        end
      end
      assign table_val[gi] = entry_reg;
    end
  endgenerate

  // Channels 11..13 are the internal reference voltages; 14/15 read as zero.
  always_comb begin
    ch_value = 10'd0;
    case (addr_sh_reg)
      4'd11:   ch_value = 10'd512;
      4'd12:   ch_value = 10'd0;
      4'd13:   ch_value = 10'd1023;
      4'd14,
      4'd15:   ch_value = 10'd0;
      default: ch_value = table_val[addr_sh_reg];
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_sh_reg    <= 10'd0;
      edge_cnt_reg <= 4'd0;
      addr_sh_reg  <= 4'd0;
    end else begin
      state_reg    <= state_next;
      tx_sh_reg    <= tx_sh_next;
      edge_cnt_reg <= edge_cnt_next;
      addr_sh_reg  <= addr_sh_next;
    end
  end

  assign edge_cnt_inc = edge_cnt_reg + 4'd1;

  always_comb begin
    state_next     = state_reg;
    tx_sh_next     = tx_sh_reg;
    edge_cnt_next  = edge_cnt_reg;
    addr_sh_next   = addr_sh_reg;
    start_req      = 1'b0;
    frame_err_next = 1'b0;
    if (cs_rise) begin
      state_next = IDLE;
      if (state_reg == SHIFT) begin
        frame_err_next = 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_next    = SHIFT;
            tx_sh_next    = result_reg;
            edge_cnt_next = 4'd0;
            addr_sh_next  = 4'd0;
          end
        end
        SHIFT: begin
          if (sclk_rise && edge_cnt_reg < 4'd4) begin
            addr_sh_next = {addr_sh_reg[2:0], addr_sync_reg[1]};
          end
          if (sclk_fall) begin
            edge_cnt_next = edge_cnt_inc;
            if (edge_cnt_inc == 4'd10) begin
              state_next = DONE;
              // A frame landing on a busy converter is reported, not queued.
              if (eoc_reg) begin
                start_req = 1'b1;
              end else begin
                frame_err_next = 1'b1;
              end
            end else begin
              tx_sh_next = {tx_sh_reg[8:0], 1'b0};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      eoc_reg         <= 1'b1;
      cnt_reg         <= 16'd0;
      conv_ch_lat_reg <= 4'd0;
      conv_val_reg    <= 10'd0;
      result_reg      <= 10'd0;
      conv_done_reg   <= 1'b0;
      conv_ch_reg     <= 4'd0;
      conv_result_reg <= 10'd0;
      frame_err_reg   <= 1'b0;
    end else begin
      conv_done_reg <= 1'b0;
      frame_err_reg <= frame_err_next;
      if (start_req) begin
        eoc_reg         <= 1'b0;
        cnt_reg         <= 16'(CONV_CYCLES);
        conv_ch_lat_reg <= addr_sh_reg;
        conv_val_reg    <= ch_value;
      end else if (!eoc_reg) begin
        if (cnt_reg == 16'd1) begin
          eoc_reg         <= 1'b1;
          cnt_reg         <= 16'd0;
          result_reg      <= conv_val_reg;
          conv_done_reg   <= 1'b1;
          conv_ch_reg     <= conv_ch_lat_reg;
          conv_result_reg <= conv_val_reg;
        end else begin
          cnt_reg <= cnt_reg - 16'd1;
        end
      end
    end
  end

  assign pins.tlc1543_data = (state_reg == SHIFT) ? tx_sh_reg[9] : 1'b0;
  assign pins.tlc1543_eoc  = eoc_reg;
  assign conv_done         = conv_done_reg;
  assign conv_ch           = conv_ch_reg;
  assign conv_result       = conv_result_reg;
  assign frame_err         = frame_err_reg;

endmodule

// File: tb/tb_tlc1543_emu.sv
// Directed bench for tlc1543_emu: pin-level frames, conversion timing, aborted
// and overlapping frames, and reset in the middle of a conversion.
module tb_tlc1543_emu;
  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       ch_wr_en = 1'b0;
  logic [3:0] ch_wr_addr = 4'd0;
  logic [9:0] ch_wr_data = 10'd0;
  logic       conv_done;
  logic [3:0] conv_ch;
  logic [9:0] conv_result;
  logic       frame_err;

  tlc1543_emu_if pins();

  tlc1543_emu #(.CONV_CYCLES(1050)) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .pins        (pins),
    .ch_wr_en    (ch_wr_en),
    .ch_wr_addr  (ch_wr_addr),
    .ch_wr_data  (ch_wr_data),
    .conv_done   (conv_done),
    .conv_ch     (conv_ch),
    .conv_result (conv_result),
    .frame_err   (frame_err)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int low_cnt = 0;

  // Running tallies of output pulses and EOC-low cycles.
  always @(negedge clk_50m) begin
    if (conv_done === 1'b1) done_cnt = done_cnt + 1;
    if (frame_err === 1'b1) err_cnt = err_cnt + 1;
    if (pins.tlc1543_eoc === 1'b0) low_cnt = low_cnt + 1;
  end

  typedef struct {
    logic [3:0] addr;
    logic [9:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk_50m);
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    ch_wr_addr = a;
    ch_wr_data = d;
    ch_wr_en   = 1'b1;
    tick();
    ch_wr_en   = 1'b0;
  endtask

  // Bit i is captured in the low phase before rise i; returns right after the last fall.
  task automatic io_bits(input logic [3:0] a, input int nfalls, output logic [9:0] bits);
    bits = 10'd0;
    for (int i = 0; i < nfalls; i++) begin
      pins.tlc1543_addr = (i < 4) ? a[3-i] : 1'b0;
      repeat (6) tick();
      bits[9-i] = pins.tlc1543_data;
      pins.tlc1543_clk = 1'b1;
      repeat (6) tick();
      pins.tlc1543_clk = 1'b0;
    end
  endtask

  task automatic cs_high();
    repeat (6) tick();
    pins.tlc1543_cs_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic run_frame(input logic [3:0] a, output logic [9:0] bits);
    pins.tlc1543_cs_n = 1'b0;
    io_bits(a, 10, bits);
    cs_high();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (pins.tlc1543_eoc !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check(name, {31'd0, pins.tlc1543_eoc}, 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    vec_t vecs[10];
    logic [9:0] bits, bits2;
    logic [9:0] model_result;
    int n, d0, e0, l0;
    bit saw_low;

    vecs[0] = '{4'd5,  10'h2AA};
    vecs[1] = '{4'd11, 10'd512};
    vecs[2] = '{4'd12, 10'd0};
    vecs[3] = '{4'd13, 10'd1023};
    vecs[4] = '{4'd14, 10'd0};
    vecs[5] = '{4'd10, 10'd640};
    vecs[6] = '{4'd0,  10'h155};
    vecs[7] = '{4'd15, 10'd0};
    vecs[8] = '{4'd7,  10'd448};
    vecs[9] = '{4'd5,  10'h2AA};

    pins.tlc1543_clk  = 1'b0;
    pins.tlc1543_cs_n = 1'b1;
    pins.tlc1543_addr = 1'b0;
    repeat (3) tick();
    check("rst_data", {31'd0, pins.tlc1543_data}, 32'd0);
    check("rst_eoc", {31'd0, pins.tlc1543_eoc}, 32'd1);
    check("rst_conv_done", {31'd0, conv_done}, 32'd0);
    check("rst_conv_ch", {28'd0, conv_ch}, 32'd0);
    check("rst_conv_result", {22'd0, conv_result}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // First frame, address 3: exact EOC fall latency and low time.
    d0 = done_cnt;
    pins.tlc1543_cs_n = 1'b0;
    io_bits(4'd3, 10, bits);
    check("frame1_bits", {22'd0, bits}, 32'd0);
    tick();
    tick();
    check("eoc_high_2cyc", {31'd0, pins.tlc1543_eoc}, 32'd1);
    tick();
    check("eoc_low_3cyc", {31'd0, pins.tlc1543_eoc}, 32'd0);
    n = 1;
    while (pins.tlc1543_eoc === 1'b0 && n < 2000) begin
      tick();
      if (pins.tlc1543_eoc === 1'b0) n++;
    end
    check("eoc_low_cycles", n, 32'd1050);
    check("done_at_eoc_rise", {31'd0, conv_done}, 32'd1);
    check("frame1_conv_ch", {28'd0, conv_ch}, 32'd3);
    check("frame1_conv_result", {22'd0, conv_result}, 32'd192);
    cs_high();
    check("frame1_done_pulses", done_cnt - d0, 32'd1);
    model_result = 10'd192;

    wr(4'd5, 10'h2AA);
    wr(4'd0, 10'h155);
    wr(4'd11, 10'd5);
    wr(4'd15, 10'd7);
    repeat (4) tick();

    for (int v = 0; v < 10; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      l0 = low_cnt;
      run_frame(vecs[v].addr, bits);
      wait_idle($sformatf("vec%0d_eoc_idle", v));
      check($sformatf("vec%0d_shift", v), {22'd0, bits}, {22'd0, model_result});
      check($sformatf("vec%0d_conv_ch", v), {28'd0, conv_ch}, {28'd0, vecs[v].addr});
      check($sformatf("vec%0d_conv_result", v), {22'd0, conv_result}, {22'd0, vecs[v].exp});
      check($sformatf("vec%0d_done_pulses", v), done_cnt - d0, 32'd1);
      check($sformatf("vec%0d_err_pulses", v), err_cnt - e0, 32'd0);
      check($sformatf("vec%0d_low_cycles", v), low_cnt - l0, 32'd1050);
      model_result = vecs[v].exp;
    end

    // MSB timing after cs_n fall, then an aborted 6-fall frame.
    d0 = done_cnt;
    e0 = err_cnt;
    pins.tlc1543_cs_n = 1'b0;
    tick();
    tick();
    check("data_before_msb", {31'd0, pins.tlc1543_data}, 32'd0);
    tick();
    check("msb_3cyc", {31'd0, pins.tlc1543_data}, 32'd1);
    io_bits(4'd13, 6, bits);
    check("abort_bits", {22'd0, bits}, {22'd0, 10'h2A0});
    cs_high();
    saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pins.tlc1543_eoc !== 1'b1) saw_low = 1'b1;
    end
    check("abort_err_pulses", err_cnt - e0, 32'd1);
    check("abort_eoc_stays_high", {31'd0, saw_low}, 32'd0);
    check("abort_done_pulses", done_cnt - d0, 32'd0);

    // Conversion on channel 13, with a second frame arriving mid-conversion.
    d0 = done_cnt;
    e0 = err_cnt;
    l0 = low_cnt;
    run_frame(4'd13, bits);
    check("post_abort_shift", {22'd0, bits}, {22'd0, model_result});
    repeat (10) tick();
    check("busy_eoc_low", {31'd0, pins.tlc1543_eoc}, 32'd0);
    run_frame(4'd3, bits2);
    check("busy_frame_shift", {22'd0, bits2}, {22'd0, model_result});
    check("busy_err_pulses", err_cnt - e0, 32'd1);
    wait_idle("busy_eoc_idle");
    check("busy_done_pulses", done_cnt - d0, 32'd1);
    check("busy_low_cycles", low_cnt - l0, 32'd1050);
    check("busy_conv_ch", {28'd0, conv_ch}, 32'd13);
    check("busy_conv_result", {22'd0, conv_result}, 32'd1023);
    model_result = 10'd1023;

    // Reset roughly 500 cycles into a conversion.
    run_frame(4'd10, bits);
    check("prereset_shift", {22'd0, bits}, {22'd0, model_result});
    repeat (490) tick();
    check("prereset_eoc_low", {31'd0, pins.tlc1543_eoc}, 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_eoc", {31'd0, pins.tlc1543_eoc}, 32'd1);
    check("midrst_conv_result", {22'd0, conv_result}, 32'd0);
    check("midrst_conv_ch", {28'd0, conv_ch}, 32'd0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (1200) tick();
    check("postrst_done_pulses", done_cnt - d0, 32'd0);
    check("postrst_eoc", {31'd0, pins.tlc1543_eoc}, 32'd1);
    check("postrst_conv_result", {22'd0, conv_result}, 32'd0);

    // After reset, result_q is zero and the value table is back to i*64.
    run_frame(4'd5, bits);
    wait_idle("postrst_eoc_idle");
    check("postrst_shift", {22'd0, bits}, 32'd0);
    check("postrst_table_ch5", {22'd0, conv_result}, 32'd320);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tlc1543_emu.md
# tlc1543_emu

Synthesizable TLC1543 device emulator: the ADC end of the 3-wire TLC1543 serial link driven by `tlc1543_top`. It samples the controller's I/O clock, chip select and address pins in the `clk_50m` domain. It shifts out the previous conversion result MSB-first and runs a timed conversion with EOC handshake. Conversion values come from a host-writable 11-channel value table, which lets the controller and downstream logic be exercised on hardware or in simulation without a real ADC.

## Interface
- `CONV_CYCLES`, default 1050: conversion time in `clk_50m` cycles (21 us); legal range 2..65535.
- `clk_50m`  in  1  system clock, 50 MHz; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tlc1543_clk`  in  1  I/O clock from the controller; asynchronous to `clk_50m`.
- `tlc1543_cs_n`  in  1  chip select, active low; asynchronous.
- `tlc1543_addr`  in  1  serial channel address, MSB first; asynchronous.
- `tlc1543_data`  out  1  serial result, MSB first.
- `tlc1543_eoc`  out  1  end of conversion; low while converting.
- `ch_wr_en`  in  1  value-table write strobe.
- `ch_wr_addr`  in  4  value-table index, 0..10; 11..15 are ignored.
- `ch_wr_data`  in  10  value to store.
- `conv_done`  out  1  one-cycle pulse when a conversion completes.
- `conv_ch`  out  4  channel of the last completed conversion.
- `conv_result`  out  10  result of the last completed conversion.
- `frame_err`  out  1  one-cycle pulse on an aborted or ignored frame.

## Operation
- **Input synchronisation and edge detection:** each of the three pins passes through a 2-FF synchroniser. Rise and fall of the synchronised `tlc1543_clk` and fall and rise of the synchronised `tlc1543_cs_n` are detected against a registered copy.
- **Frame FSM** (states IDLE, SHIFT, DONE):
  - IDLE → SHIFT on a cs_n fall. Actions: load `tx_sh` from `result_q`; clear `edge_cnt` (4 bits) and `addr_sh` (4 bits).
  - SHIFT, on each I/O-clock rise: while `edge_cnt` < 4, shift `tlc1543_addr` into `addr_sh` LSB side.
  - SHIFT, on each I/O-clock fall: increment `edge_cnt`.
    - Falls 1..9: `tx_sh` shifts left.
    - Fall 10: start a conversion with channel `addr_sh`, then go to DONE.
  - DONE: further I/O-clock edges are ignored.
  - Any state → IDLE on a cs_n rise. If the FSM is still in SHIFT, pulse `frame_err` and start no conversion.
- **Serial output:** `tlc1543_data` = `tx_sh[9]` in SHIFT; 0 in IDLE and DONE.
- **Conversion:**
  - Start: drive `tlc1543_eoc` low, latch the channel and its value, and load a 16-bit down-counter with `CONV_CYCLES`.
  - Completion, when the counter reaches 1:
    - `result_q` ← latched value
    - `tlc1543_eoc` high
    - `conv_done` pulses
    - `conv_ch` and `conv_result` update
- **Channel values:**
  - 0..10: value-table entry.
  - 11: 10'd512.
  - 12: 10'd0.
  - 13: 10'd1023.
  - 14 (power-down) and 15: 10'd0.
- **Value table:** 11 × 10-bit entries, reset to entry i = i×64. Written on `ch_wr_en` at any time. A write in the same cycle as a conversion start is not captured by that conversion (read-before-write).
- **Frame during conversion:** a cs_n fall while EOC is low still enters SHIFT and shifts out the old `result_q`. At its 10th fall it pulses `frame_err` and starts no new conversion. The running conversion is unaffected.
- **Mid-operation reset:** `rst` asserted at any point returns all state to reset values immediately.
- **Reset values:**
  - `tlc1543_data` 0, `tlc1543_eoc` 1.
  - `conv_done` 0, `conv_ch` 0, `conv_result` 0, `frame_err` 0.
  - FSM IDLE, `result_q` 0, counter 0.

## Timing
- Pin edge to internal edge pulse: 3 `clk_50m` cycles (2 synchroniser stages + 1 detect register).
- `tlc1543_data`:
  - Shows the MSB 3 cycles after the cs_n fall.
  - Each subsequent bit appears 3 cycles after the corresponding I/O-clock fall.
- `tlc1543_eoc` falls 3 cycles after the 10th I/O-clock fall. It rises exactly `CONV_CYCLES` cycles after falling, in the same cycle as `conv_done`.
- Addresses are sampled at the synchronised rise. `tlc1543_addr` must be stable from ≥1 cycle before to ≥3 cycles after the `tlc1543_clk` pin rise.
- Pin constraints:
  - I/O-clock high and low times ≥ 4 `clk_50m` cycles.
  - cs_n high time ≥ 4 cycles.
- Simultaneous conversion completion and conversion start cannot occur: a start requires EOC high.

## Test plan
- **Reset defaults:** apply reset, then a frame with address 4'd3 and no table writes → `conv_result` = 192, `conv_ch` = 3, EOC low for exactly 1050 cycles.
- **Written value read back:** write channel 5 = 10'h2AA; frame with address 5; second frame with any address → second frame shifts out 1010101010 MSB first, one bit per I/O-clock fall.
- **Internal test voltages:** addresses 11, 12, 13 → results 512, 0, 1023; address 14 → result 0.
- **Aborted frame:** raise cs_n after 6 I/O-clock falls → `frame_err` pulses once, EOC stays high, `result_q` unchanged.
- **Frame during conversion:** cs_n fall while EOC is low, 10 clocks → old result shifted out, `frame_err` pulse, a single `conv_done` at the original completion time.
- **Reset mid-conversion:** assert `rst` 500 cycles into a conversion → EOC = 1, `conv_done` never pulses, `conv_result` = 0.
